// File: rtl/gpr_wb_pkg.sv
// rtl/gpr_wb_pkg.sv - shared defaults and constants for the GPR writeback arbiter
package gpr_wb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // Requester slots on the writeback port; lower index wins under fixed priority
  typedef enum int {
    REQ_ALU = 0,
    REQ_LD  = 1,
    REQ_MD  = 2
  } req_id_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_wb_rr_arb.sv
// rtl/gpr_wb_rr_arb.sv - grant logic, round-robin when GPR_WB_RR_EN is defined, else fixed priority
module gpr_wb_rr_arb
  import gpr_wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

`ifdef GPR_WB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;

  // Scan from the farthest slot back to ptr+1 so the nearest valid requester overwrites the rest
  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Remember the last winner; reset value makes requester 0 the first candidate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= PW'(NREQ - 1);
    end else if (|grant) begin
      ptr <= gidx;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, reset};

  // Lowest set bit wins
  assign grant = req & (~req + 1'b1);
`endif

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR writeback arbiter with pending-write scoreboard (policy via GPR_WB_RR_EN)
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic               rsv_ready,
  input  logic [AW-1:0]      chk_a,
  input  logic [AW-1:0]      chk_b,
  output logic               hazard_a,
  output logic               hazard_b,
  output logic [AW-1:0]      RegWrite,
  output logic               WriteEnable,
  output logic [DW-1:0]      WriteData,
  output logic               err
);

  localparam int            NREG = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NREQ-1:0] grant;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            xfer;
  logic            rsv_take;

  gpr_wb_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  // No grants while reset is held, so nothing is taken from a requester that must re-present
  assign req_ready = reset ? grant : '0;
  assign xfer      = |req_ready;

  // Route the granted requester's address and data to the output stage
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Reservation looks only at current busy state; a same-edge clear costs one stall cycle
  assign rsv_ready = (rsv_addr == ZERO) || !busy[rsv_addr];
  assign rsv_take  = rsv_valid && rsv_ready && (rsv_addr != ZERO);

  // Grant clears, reservation sets afterwards so the set wins on a shared register
  always_comb begin
    busy_nxt = busy;
    if (xfer) begin
      busy_nxt[sel_addr] = 1'b0;
    end
    if (rsv_take) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Registered GPR write port; $0 writes are consumed with WriteEnable low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite    <= '0;
      WriteData   <= '0;
      WriteEnable <= 1'b0;
    end else if (xfer) begin
      RegWrite    <= sel_addr;
      WriteData   <= sel_data;
      WriteEnable <= (sel_addr != ZERO);
    end else begin
      WriteEnable <= 1'b0;
    end
  end

  // Sticky flag for a write to a register nobody reserved
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (xfer && (sel_addr != ZERO) && !busy[sel_addr]) begin
      err <= 1'b1;
    end
  end

  // Output-register term covers the cycle between grant and GPR commit
  assign hazard_a = (chk_a != ZERO) && (busy[chk_a] || (WriteEnable && (RegWrite == chk_a)));
  assign hazard_b = (chk_b != ZERO) && (busy[chk_b] || (WriteEnable && (RegWrite == chk_b)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - directed self-checking bench for gpr_wb_arbiter (honours GPR_WB_RR_EN)
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  chk_a;
  logic [4:0]  chk_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [4:0]  RegWrite;
  logic        WriteEnable;
  logic [31:0] WriteData;
  logic        err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  gpr_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsv_valid   (rsv_valid),
    .rsv_addr    (rsv_addr),
    .rsv_ready   (rsv_ready),
    .chk_a       (chk_a),
    .chk_b       (chk_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .RegWrite    (RegWrite),
    .WriteEnable (WriteEnable),
    .WriteData   (WriteData),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         rsv_list[7] = '{1, 2, 3, 5, 6, 8, 10};
    int         pool[4]     = '{5, 6, 8, 10};
    int         exp_g[4];
    logic [4:0] cur[3];
    logic [4:0] last;

`ifdef GPR_WB_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    reset     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    chk_a     = '0;
    chk_b     = '0;

    // reset held across an edge with all requesters valid
    step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(WriteEnable), 64'd0);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(dut.busy), 64'd0);
    chk("rst_rsv_ready", 64'(rsv_ready), 64'd1);

    reset = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    chk("first_we_zero_addr", 64'(WriteEnable), 64'd0);

    // single write to $4
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    chk_a     = 5'd4;
    #1;
    chk("sw_rsv_ready", 64'(rsv_ready), 64'd1);
    chk("sw_hazard_pre", 64'(hazard_a), 64'd0);
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd4};
    req_data  = {32'd0, 32'd0, 32'd5};
    #1;
    chk("sw_hazard_busy", 64'(hazard_a), 64'd1);
    chk("sw_req_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    #1;
    chk("sw_we", 64'(WriteEnable), 64'd1);
    chk("sw_regwrite", 64'(RegWrite), 64'd4);
    chk("sw_wdata", 64'(WriteData), 64'd5);
    chk("sw_hazard_outreg", 64'(hazard_a), 64'd1);
    chk("sw_err", 64'(err), 64'd0);
    step();
    #1;
    chk("sw_we_one_cycle", 64'(WriteEnable), 64'd0);
    chk("sw_hazard_clear", 64'(hazard_a), 64'd0);

    // $0 writes from load then mul/div
    req_valid = 3'b010;
    req_addr  = '0;
    req_data  = {32'd0, 32'd5, 32'd0};
    chk_b     = 5'd0;
    #1;
    chk("z_req_ready_ld", 64'(req_ready), 64'b010);
    chk("z_hazard_b_pre", 64'(hazard_b), 64'd0);
    step();
    req_valid = 3'b100;
    req_data  = {32'd9, 64'd0};
    #1;
    chk("z_we_ld", 64'(WriteEnable), 64'd0);
    chk("z_err_ld", 64'(err), 64'd0);
    chk("z_hazard_b_post", 64'(hazard_b), 64'd0);
    chk("z_req_ready_md", 64'(req_ready), 64'b100);
    step();
    req_valid = 3'b000;
    #1;
    chk("z_we_md", 64'(WriteEnable), 64'd0);

    // contention: reserve targets, then hold all three valid
    for (int r = 0; r < 7; r++) begin
      rsv_valid = 1'b1;
      rsv_addr  = 5'(rsv_list[r]);
      step();
    end
    rsv_valid = 1'b0;
    cur[0] = 5'd1;
    cur[1] = 5'd2;
    cur[2] = 5'd3;
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      req_addr = {cur[2], cur[1], cur[0]};
      req_data = {27'd0, cur[2], 27'd0, cur[1], 27'd0, cur[0]};
      #1;
      chk($sformatf("ct_grant%0d", k), 64'(req_ready), 64'(3'b001 << exp_g[k]));
      last = cur[exp_g[k]];
      cur[exp_g[k]] = 5'(pool[k]);
      step();
      chk($sformatf("ct_regwrite%0d", k), 64'(RegWrite), 64'(last));
      chk($sformatf("ct_wdata%0d", k), 64'(WriteData), 64'(last));
      chk($sformatf("ct_we%0d", k), 64'(WriteEnable), 64'd1);
    end
    req_valid = 3'b000;
    chk("ct_err", 64'(err), 64'd0);

    // reserve $7 while a grant to $7 happens on the same edge
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    step();
    req_valid = 3'b001;
    req_addr  = {10'd0, 5'd7};
    req_data  = {64'd0, 32'h77};
    #1;
    chk("sc_rsv_stall", 64'(rsv_ready), 64'd0);
    chk("sc_req_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    #1;
    chk("sc_rsv_ready_next", 64'(rsv_ready), 64'd1);
    chk("sc_regwrite", 64'(RegWrite), 64'd7);
    step();
    rsv_valid = 1'b0;
    chk_a     = 5'd7;
    #1;
    chk("sc_we_idle", 64'(WriteEnable), 64'd0);
    chk("sc_hazard_busy7", 64'(hazard_a), 64'd1);
    chk("sc_busy7", 64'(dut.busy[7]), 64'd1);
    chk("sc_rsv_ready_busy", 64'(rsv_ready), 64'd0);

    // unreserved write to $9
    req_valid = 3'b001;
    req_addr  = {10'd0, 5'd9};
    req_data  = {64'd0, 32'd9};
    step();
    req_valid = 3'b000;
    #1;
    chk("ur_err", 64'(err), 64'd1);
    chk("ur_regwrite", 64'(RegWrite), 64'd9);
    chk("ur_we", 64'(WriteEnable), 64'd1);
    step();
    chk("ur_err_sticky", 64'(err), 64'd1);

    // asynchronous reset in the middle of traffic
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd7, 5'd0};
    req_data  = {32'd0, 32'h70, 32'd0};
    step();
    chk("ar_we_before", 64'(WriteEnable), 64'd1);
    req_valid = 3'b111;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_err", 64'(err), 64'd0);
    chk("ar_we", 64'(WriteEnable), 64'd0);
    chk("ar_regwrite", 64'(RegWrite), 64'd0);
    chk("ar_wdata", 64'(WriteData), 64'd0);
    chk("ar_busy", 64'(dut.busy), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd0);
    chk("ar_hazard_a", 64'(hazard_a), 64'd0);
    reset     = 1'b1;
    req_valid = 3'b000;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
